// File: rtl/filter_load_controller.sv
// Loads one 3x3 or 5x5 filter from weight memory into a PE weight bank.
// Reads sequentially with a rd/ack handshake and strobes one bank register per word.
module filter_load_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic              filter_sz,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_en,
  output logic [IDX_W-1:0]  reg_idx,
  output logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               reg_en_q, reg_en_d;
  logic [IDX_W-1:0]   reg_idx_q, reg_idx_d;
  logic [DATA_W-1:0]  reg_data_q, reg_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   idx_next_s;

  assign idx_next_s = idx_q + IDX_W'(1);

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    last_d     = last_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    reg_en_d   = 1'b0;
    reg_idx_d  = reg_idx_q;
    reg_data_d = reg_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (state_q != ST_IDLE && abort) begin
      // Abort drops everything; a same-cycle ack is discarded.
      state_d  = ST_IDLE;
      mem_rd_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d    = ST_REQ;
            base_d     = base_addr;
            last_d     = filter_sz ? IDX_W'(24) : IDX_W'(8);
            idx_d      = {IDX_W{1'b0}};
            mem_rd_d   = 1'b1;
            mem_addr_d = base_addr;
            busy_d     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            reg_en_d   = 1'b1;
            reg_idx_d  = idx_q;
            reg_data_d = mem_data;
            if (idx_q == last_q) begin
              mem_rd_d = 1'b0;
              state_d  = ST_FLUSH;
            end else begin
              idx_d      = idx_next_s;
              mem_addr_d = base_q + ADDR_W'(idx_next_s);
            end
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_FLUSH: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      base_q     <= {ADDR_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      last_q     <= {IDX_W{1'b0}};
      mem_rd_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      reg_en_q   <= 1'b0;
      reg_idx_q  <= {IDX_W{1'b0}};
      reg_data_q <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      reg_en_q   <= reg_en_d;
      reg_idx_q  <= reg_idx_d;
      reg_data_q <= reg_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign reg_en   = reg_en_q;
  assign reg_idx  = reg_idx_q;
  assign reg_data = reg_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_filter_load_controller.sv
// Randomized bench for filter_load_controller with a transaction-level reference model
// compared every cycle, plus literal checks on latency, addresses, strobes, abort and reset.
module tb_filter_load_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, filter_sz = 1'b0, mem_ack = 1'b0;
  logic [15:0] base_addr = 16'h0000, mem_data = 16'h0000;
  logic        mem_rd, reg_en, busy, done;
  logic [15:0] mem_addr, reg_data;
  logic [4:0]  reg_idx;

  filter_load_controller #(.DATA_W(16), .ADDR_W(16), .IDX_W(5)) dut (
    .CLK(clk), .RST(rst), .start(start), .abort(abort), .filter_sz(filter_sz),
    .base_addr(base_addr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .reg_en(reg_en), .reg_idx(reg_idx), .reg_data(reg_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: words acknowledged so far, cycles elapsed since the last word
  bit          m_active;
  int          m_k, m_count, m_tail;
  logic [15:0] m_base;
  logic        e_reg_en, e_done;
  logic [15:0] e_addr, e_data;
  logic [4:0]  e_idx;

  logic [15:0] obs_addr[$];
  int          obs_idx[$];
  int          done_cnt, done_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_k = 0; m_count = 0; m_tail = 0; m_base = 16'h0000;
    e_reg_en = 1'b0; e_done = 1'b0; e_addr = 16'h0000; e_data = 16'h0000; e_idx = 5'd0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit sz, input logic [15:0] b,
                            input bit ack, input logic [15:0] d);
    e_reg_en = 1'b0;
    e_done   = 1'b0;
    if (!m_active) begin
      if (s && !a) begin
        m_active = 1'b1; m_base = b; m_count = sz ? 25 : 9; m_k = 0; m_tail = 0;
        e_addr = b;
      end
    end else if (a) begin
      m_active = 1'b0;
    end else if (m_k < m_count) begin
      if (ack) begin
        e_reg_en = 1'b1; e_idx = 5'(m_k); e_data = d;
        m_k++;
        if (m_k < m_count) e_addr = m_base + 16'(m_k);
      end
    end else begin
      m_tail++;
      if (m_tail == 2) begin
        m_active = 1'b0;
        e_done = 1'b1;
      end
    end
  endtask

  task automatic step(input bit s, input bit a, input bit sz, input logic [15:0] b,
                      input bit ack, input logic [15:0] d);
    start = s; abort = a; filter_sz = sz; base_addr = b; mem_ack = ack; mem_data = d;
    @(posedge clk);
    cyc++;
    model_step(s, a, sz, b, ack, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0; mem_ack = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_idx.delete(); done_cnt = 0; done_cyc = -1;
  endtask

  // Start a load, then ack with random delays until the model finishes or aborts
  task automatic run_load(input bit sz, input logic [15:0] b, input int maxd,
                          input int abort_at, input bit noise, output int start_cyc);
    int wait_c, n;
    bit ack;
    clear_obs();
    start_cyc = cyc;
    step(1'b1, 1'b0, sz, b, 1'b0, 16'h0000);
    wait_c = $urandom_range(0, maxd);
    n = 0;
    while (m_active && n < 400) begin
      n++;
      if (abort_at >= 0 && m_k == abort_at) begin
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'(($urandom)));
      end else begin
        ack = (wait_c == 0);
        step(noise && ($urandom_range(0, 7) == 0), 1'b0,
             noise ? 1'($urandom) : sz, noise ? 16'($urandom) : b, ack, 16'($urandom));
        if (ack) wait_c = $urandom_range(0, maxd);
        else wait_c--;
      end
    end
    chk("load_timeout", 32'(n < 400), 32'd1);
  endtask

  // Per-cycle comparison against the model, plus observation logging
  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_rd", 32'(mem_rd), 32'(m_active && (m_k < m_count)));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("reg_en", 32'(reg_en), 32'(e_reg_en));
      chk("reg_idx", 32'(reg_idx), 32'(e_idx));
      chk("reg_data", 32'(reg_data), 32'(e_data));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      if (mem_rd && mem_ack && !abort) obs_addr.push_back(mem_addr);
      if (reg_en) obs_idx.push_back(int'(reg_idx));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    int sc;
    logic [15:0] a;
    model_reset();
    clear_obs();
    do_reset();
    #2;
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    idle(2);

    // T1: zero-wait 9-word load
    run_load(1'b0, 16'h0100, 0, -1, 1'b0, sc);
    idle(2);
    chk("t1_latency", 32'(done_cyc - sc), 32'd12);
    chk("t1_strobes", 32'(obs_idx.size()), 32'd9);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    if (obs_addr.size() == 9)
      for (int i = 0; i < 9; i++) chk("t1_addr", 32'(obs_addr[i]), 32'h100 + 32'(i));
    else chk("t1_addr_cnt", 32'(obs_addr.size()), 32'd9);

    // T1b: zero-wait 25-word latency
    run_load(1'b1, 16'h2000, 0, -1, 1'b0, sc);
    idle(2);
    chk("t1b_latency", 32'(done_cyc - sc), 32'd28);

    // T2: 25 words, random ack delays, start/size/base noise while busy
    run_load(1'b1, 16'h4000, 3, -1, 1'b1, sc);
    idle(2);
    chk("t2_strobes", 32'(obs_idx.size()), 32'd25);
    if (obs_idx.size() == 25)
      for (int i = 0; i < 25; i++) chk("t2_order", 32'(obs_idx[i]), 32'(i));
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // T3: address wrap
    run_load(1'b0, 16'hFFFE, 1, -1, 1'b0, sc);
    idle(2);
    if (obs_addr.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        a = 16'hFFFE + 16'(i);
        chk("t3_addr", 32'(obs_addr[i]), 32'(a));
      end
      chk("t3_wrap0", 32'(obs_addr[2]), 32'h0000);
    end else chk("t3_addr_cnt", 32'(obs_addr.size()), 32'd9);

    // T4: abort after the 4th ack, then a clean load
    run_load(1'b0, 16'h0300, 1, 4, 1'b0, sc);
    chk("t4_busy_after_abort", 32'(busy), 32'd0);
    idle(3);
    chk("t4_strobes", 32'(obs_idx.size()), 32'd4);
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    run_load(1'b0, 16'h0300, 0, -1, 1'b0, sc);
    idle(2);
    chk("t4_clean_strobes", 32'(obs_idx.size()), 32'd9);
    chk("t4_clean_done", 32'(done_cnt), 32'd1);

    // T5: start together with abort in IDLE
    step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 16'h0000);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mem_rd", 32'(mem_rd), 32'd0);
    idle(2);

    // T6: asynchronous reset between clock edges mid-load
    step(1'b1, 1'b0, 1'b1, 16'h0A00, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0A00, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 16'h0A00, 1'b1, 16'h5678);
    chk("t6_pre_rd", 32'(mem_rd), 32'd1);
    chk("t6_pre_en", 32'(reg_en), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rd_drop", 32'(mem_rd), 32'd0);
    chk("t6_en_drop", 32'(reg_en), 32'd0);
    chk("t6_busy_drop", 32'(busy), 32'd0);
    do_reset();
    run_load(1'b0, 16'h0B00, 2, -1, 1'b0, sc);
    idle(2);
    chk("t6_after_strobes", 32'(obs_idx.size()), 32'd9);
    chk("t6_after_done", 32'(done_cnt), 32'd1);

    // Random loads with occasional aborts
    for (int t = 0; t < 12; t++) begin
      run_load(1'($urandom), 16'($urandom), 3,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, 1'b1, sc);
      idle($urandom_range(0, 3));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
